// File: rtl/gbuff_port_ctrl.sv
// Burst controller for one single-port global buffer: write beats stream straight
// into the buffer, read beats return through a 2-entry skid FIFO with backpressure.
module gbuff_port_ctrl #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [ADDR_BITS-1:0] cmd_len,
    input  logic                 wdata_valid,
    output logic                 wdata_ready,
    input  logic [DATA_BITS-1:0] wdata,
    output logic                 rdata_valid,
    input  logic                 rdata_ready,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 buf_wr_en,
    output logic [ADDR_BITS-1:0] buf_index,
    output logic [DATA_BITS-1:0] buf_data_in,
    input  logic [DATA_BITS-1:0] buf_data_out
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [ADDR_BITS-1:0]   r_curAddr;
    logic [ADDR_BITS:0]     r_beatsLeft;
    logic                   r_inflight;
    logic                   r_done;
    logic [DATA_BITS-1:0]   r_fifoMem [2];
    logic                   r_rdPtr;
    logic                   r_wrPtr;
    logic [1:0]             r_fifoCount;

    logic                   w_accept;
    logic                   w_wrBeat;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_slotOk;
    logic                   w_issue;
    logic                   w_lastBeat;
    logic                   w_drained;

    assign w_accept   = (r_state == IDLE) && cmd_valid;
    assign w_wrBeat   = (r_state == WRITE) && wdata_valid;
    assign w_pop      = (r_fifoCount != 2'd0) && rdata_ready;
    assign w_push     = r_inflight;
    // A slot is free if the FIFO, counting the read still in flight, will hold < 2 words.
    assign w_slotOk   = ({1'b0, r_fifoCount} + {2'b00, r_inflight} - {2'b00, w_pop}) < 3'd2;
    assign w_issue    = (r_state == READ) && w_slotOk;
    assign w_lastBeat = (r_beatsLeft == (ADDR_BITS+1)'(1));
    assign w_drained  = !r_inflight && ((r_fifoCount == 2'd0) || ((r_fifoCount == 2'd1) && w_pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_nextState = cmd_write ? WRITE : READ;
            WRITE:   if (w_wrBeat && w_lastBeat) w_nextState = IDLE;
            READ:    if (w_issue && w_lastBeat) w_nextState = DRAIN;
            DRAIN:   if (w_drained) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_curAddr   <= '0;
            r_beatsLeft <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
            r_rdPtr     <= 1'b0;
            r_wrPtr     <= 1'b0;
            r_fifoCount <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifoMem[i] <= '0;
            end
        end else begin
            r_done     <= (r_state != IDLE) && (w_nextState == IDLE);
            r_inflight <= w_issue;
            if (w_accept) begin
                r_curAddr   <= cmd_addr;
                r_beatsLeft <= {1'b0, cmd_len} + (ADDR_BITS+1)'(1);
            end else if (w_wrBeat || w_issue) begin
                r_curAddr   <= r_curAddr + ADDR_BITS'(1);
                r_beatsLeft <= r_beatsLeft - (ADDR_BITS+1)'(1);
            end
            if (w_push) begin
                r_fifoMem[r_wrPtr] <= buf_data_out;
                r_wrPtr            <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_fifoCount <= r_fifoCount + {1'b0, w_push} - {1'b0, w_pop};
            assert (!(w_push && !w_pop && (r_fifoCount == 2'd2)));
        end
    end

    always_comb begin
        cmd_ready   = (r_state == IDLE);
        busy        = (r_state != IDLE);
        wdata_ready = (r_state == WRITE);
        buf_wr_en   = w_wrBeat;
        buf_index   = r_curAddr;
        buf_data_in = (r_state == WRITE) ? wdata : '0;
        rdata_valid = (r_fifoCount != 2'd0);
        rdata       = r_fifoMem[r_rdPtr];
        done        = r_done;
    end

endmodule

// File: tb/tb_gbuff_port_ctrl.sv
// Bench for gbuff_port_ctrl: a shadow memory plus an expected-read queue predict every
// buffer access, read beat and done pulse from the burst rules alone.
module tb_gbuff_port_ctrl;

    localparam int MAXC = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_len;
    logic       wdata_valid, wdata_ready;
    logic [7:0] wdata;
    logic       rdata_valid, rdata_ready;
    logic [7:0] rdata;
    logic       busy, done, buf_wr_en;
    logic [7:0] buf_index, buf_data_in;
    logic [7:0] buf_data_out;

    logic [7:0] bufMem  [256];
    logic [7:0] shadow  [256];
    logic [7:0] dataBuf [256];
    logic [7:0] expQ [$];

    int   checks = 0;
    int   failures = 0;
    int   cycleNo = 0;
    int   mMode = 0;
    int   mLeft = 0;
    int   mBeat = 0;
    int   mPops = 0;
    int   acceptCyc = 0;
    logic firstSeen = 1'b0;
    logic expDone = 1'b0;
    logic [7:0] mAddr = 8'h00;
    int   stallPat [7] = '{1, 0, 0, 1, 1, 0, 1};

    always #5 clk = ~clk;

    gbuff_port_ctrl #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .busy(busy), .done(done),
        .buf_wr_en(buf_wr_en), .buf_index(buf_index),
        .buf_data_in(buf_data_in), .buf_data_out(buf_data_out)
    );

    // Single-port buffer: write on the edge, registered read of the addressed word.
    always @(posedge clk) begin
        if (buf_wr_en) bufMem[buf_index] <= buf_data_in;
        buf_data_out <= bufMem[buf_index];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic cv, input logic cw, input logic [7:0] ca,
                                 input logic [7:0] cl, input logic wv, input logic [7:0] wd,
                                 input logic rr, input logic rs);
        cmd_valid   = cv;
        cmd_write   = cw;
        cmd_addr    = ca;
        cmd_len     = cl;
        wdata_valid = wv;
        wdata       = wd;
        rdata_ready = rr;
        rst         = rs;
    endtask

    // Compare the DUT against the model for this cycle, then advance the model.
    task automatic checkOutput();
        int   prevMode;
        logic newDone;
        prevMode = mMode;
        newDone  = 1'b0;
        cycleNo++;
        chk("busy", busy, prevMode != 0);
        chk("cmd_ready", cmd_ready, prevMode == 0);
        chk("done", done, expDone);
        chk("wdata_ready", wdata_ready, prevMode == 1);
        chk("buf_wr_en", buf_wr_en, (prevMode == 1) && wdata_valid);
        if (prevMode != 1) chk("buf_data_in_idle", buf_data_in, 0);
        if (prevMode == 0) chk("rdata_valid_idle", rdata_valid, 0);
        if (prevMode == 0 && cmd_valid) begin
            mMode     = cmd_write ? 1 : 2;
            mAddr     = cmd_addr;
            mLeft     = int'(cmd_len) + 1;
            mBeat     = 0;
            mPops     = 0;
            acceptCyc = cycleNo;
            firstSeen = 1'b0;
            if (!cmd_write) begin
                for (int k = 0; k <= int'(cmd_len); k++) expQ.push_back(shadow[8'(int'(cmd_addr) + k)]);
            end
        end else if (prevMode == 1 && wdata_valid) begin
            chk("wr_index", buf_index, mAddr);
            chk("wr_data", buf_data_in, wdata);
            shadow[mAddr] = wdata;
            mAddr = mAddr + 8'd1;
            mBeat++;
            mLeft--;
            if (mLeft == 0) begin
                mMode   = 0;
                newDone = 1'b1;
            end
        end else if (prevMode == 2) begin
            if (rdata_valid && !firstSeen) begin
                firstSeen = 1'b1;
                chk("rd_latency", cycleNo - acceptCyc, 3);
            end
            if (rdata_valid && rdata_ready) begin
                chk("rd_data", rdata, expQ.pop_front());
                mPops++;
                if (expQ.size() == 0) begin
                    mMode   = 0;
                    newDone = 1'b1;
                end
            end
        end
        expDone = newDone;
        if (rst) begin
            mMode   = 0;
            expDone = 1'b0;
            expQ.delete();
        end
    endtask

    task automatic doCycle();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        mMode   = 0;
        expDone = 1'b0;
        expQ.delete();
    endtask

    // mode 0: continuous valid, 1: random valid with junk commands, 2: fixed stall pattern
    task automatic writeBurst(input logic [7:0] addr, input logic [7:0] len, input int mode);
        int   iters;
        logic v;
        applyStimulus(1, 1, addr, len, 0, 8'h00, 1, 0);
        doCycle();
        iters = 0;
        while (mMode == 1 && iters < MAXC) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 2) v = (iters < 7) ? logic'(stallPat[iters]) : 1'b1;
            else                v = ($urandom_range(0, 3) != 0);
            applyStimulus((mode == 1) ? logic'($urandom_range(0, 1)) : 1'b0, 1'b0,
                          8'($urandom), 8'($urandom), v, dataBuf[mBeat], 1, 0);
            doCycle();
            iters++;
        end
        if (mMode != 0) begin
            chk("wr_timeout", mMode, 0);
            doReset();
        end
        if (mode == 0) chk("wr_cycles", iters, int'(len) + 1);
        if (mode == 2) chk("wr_stall_cycles", iters, 7);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0);
        doCycle();
    endtask

    // mode 0: always ready, 1: random ready with junk commands, 2: ready held low 10 cycles
    task automatic readBurst(input logic [7:0] addr, input logic [7:0] len, input int mode);
        int   iters;
        logic r;
        applyStimulus(1, 0, addr, len, 0, 8'h00, 1, 0);
        doCycle();
        iters = 0;
        while (mMode == 2 && iters < MAXC) begin
            if (mode == 0)      r = 1'b1;
            else if (mode == 2) r = (iters >= 10);
            else                r = ($urandom_range(0, 2) != 0);
            applyStimulus((mode == 1) ? logic'($urandom_range(0, 1)) : 1'b0, 1'b1,
                          8'($urandom), 8'($urandom), 0, 8'h00, r, 0);
            doCycle();
            iters++;
            if (mode == 2 && iters == 10) begin
                chk("bp_rdata_valid", rdata_valid, 1);
                chk("bp_rdata_head", rdata, expQ[0]);
                chk("bp_two_issued", buf_index, addr + 8'd2);
            end
        end
        if (mMode != 0) begin
            chk("rd_timeout", mMode, 0);
            doReset();
        end
        if (mode == 0) chk("rd_cycles", iters, int'(len) + 3);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0);
        doCycle();
    endtask

    initial begin
        int iters;
        doReset();
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_wdata_ready", wdata_ready, 0);
        chk("rst_rdata_valid", rdata_valid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_buf_wr_en", buf_wr_en, 0);
        chk("rst_buf_index", buf_index, 0);
        chk("rst_buf_data_in", buf_data_in, 0);

        $display("[TB] full depth write/read");
        for (int k = 0; k < 256; k++) dataBuf[k] = 8'(k);
        writeBurst(8'h00, 8'hFF, 0);
        readBurst(8'h00, 8'hFF, 0);

        $display("[TB] basic burst at 0x10");
        for (int k = 0; k < 4; k++) dataBuf[k] = 8'hA1 + 8'(k);
        writeBurst(8'h10, 8'd3, 0);
        readBurst(8'h10, 8'd3, 0);

        $display("[TB] wrap-around at 0xFE");
        for (int k = 0; k < 4; k++) dataBuf[k] = 8'(k + 1);
        writeBurst(8'hFE, 8'd3, 0);
        readBurst(8'hFE, 8'd3, 0);

        $display("[TB] read backpressure");
        readBurst(8'h10, 8'd7, 2);

        $display("[TB] write stalls");
        for (int k = 0; k < 4; k++) dataBuf[k] = 8'h55 + 8'(k);
        writeBurst(8'h40, 8'd3, 2);
        readBurst(8'h40, 8'd3, 0);

        $display("[TB] reset mid-read");
        applyStimulus(1, 0, 8'h10, 8'd7, 0, 8'h00, 1, 0);
        doCycle();
        iters = 0;
        while (mPops < 2 && iters < MAXC) begin
            applyStimulus(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0);
            doCycle();
            iters++;
        end
        chk("mid_read_progress", mPops, 2);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 1);
        doCycle();
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rdata_valid", rdata_valid, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        doCycle();
        readBurst(8'hFE, 8'd3, 0);

        $display("[TB] randomized bursts");
        for (int b = 0; b < 24; b++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 256; k++) dataBuf[k] = 8'($urandom);
                writeBurst(8'($urandom), 8'($urandom_range(0, 15)), 1);
            end else begin
                readBurst(8'($urandom), 8'($urandom_range(0, 15)), 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
